// File: rtl/udp_byte_packer.sv
// Packs a stream of UDP payload bytes into 32-bit words, first byte in [31:24].
// A word closes on its fourth byte or on a packet's last byte; unused lanes carry PAD.
module udp_byte_packer #(
  parameter logic [7:0] PAD   = 8'hFF,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             m_valid,
  output logic [31:0]      m_data,
  output logic [3:0]       m_keep,
  output logic             m_last,
  input  logic             m_ready,
  output logic [CNT_W-1:0] pkt_count
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; the source holds valid and its payload stable until then.
  logic [1:0]  lane;
  logic [23:0] asm_q;
  logic        accept;
  logic        close;
  logic        out_fire;
  logic [31:0] word_next;
  logic [3:0]  keep_next;

  // One output slot: new bytes are taken only if the slot is empty or draining now.
  assign s_ready  = !m_valid || m_ready;
  assign accept   = s_valid && s_ready;
  assign close    = accept && (s_last || (lane == 2'd3));
  assign out_fire = m_valid && m_ready;

  // Only lanes below the current one come from the assembly register, so stale
  // assembly bytes never reach m_data.
  always_comb begin
    word_next = {PAD, PAD, PAD, PAD};
    keep_next = 4'b0000;
    case (lane)
      2'd0: begin
        word_next = {s_data, PAD, PAD, PAD};
        keep_next = 4'b1000;
      end
      2'd1: begin
        word_next = {asm_q[23:16], s_data, PAD, PAD};
        keep_next = 4'b1100;
      end
      2'd2: begin
        word_next = {asm_q[23:8], s_data, PAD};
        keep_next = 4'b1110;
      end
      default: begin
        word_next = {asm_q, s_data};
        keep_next = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane      <= 2'd0;
      asm_q     <= 24'h0;
      m_valid   <= 1'b0;
      m_data    <= 32'h0;
      m_keep    <= 4'h0;
      m_last    <= 1'b0;
      pkt_count <= '0;
    end else begin
      if (close) begin
        lane <= 2'd0;
      end else if (accept) begin
        case (lane)
          2'd0:    asm_q[23:16] <= s_data;
          2'd1:    asm_q[15:8]  <= s_data;
          default: asm_q[7:0]   <= s_data;
        endcase
        lane <= lane + 2'd1;
      end

      // A closing word replaces a draining one in the same edge, keeping m_valid high.
      if (close) begin
        m_valid <= 1'b1;
        m_data  <= word_next;
        m_keep  <= keep_next;
        m_last  <= s_last;
      end else if (out_fire) begin
        m_valid <= 1'b0;
      end

      if (out_fire && m_last) begin
        pkt_count <= pkt_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_udp_byte_packer.sv
// Directed bench for udp_byte_packer: a default instance plus a small-counter,
// alternate-PAD instance fed the same stream to exercise counter wrap and padding.
module tb_udp_byte_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_ready;
  logic [15:0] pkt_count;

  logic        s_ready2;
  logic        m_valid2;
  logic [31:0] m_data2;
  logic [3:0]  m_keep2;
  logic        m_last2;
  logic [2:0]  pkt_count2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Expected words: {data[31:0], keep[3:0], last}
  logic [36:0] exp_q[$];

  udp_byte_packer dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
    .m_ready(m_ready), .pkt_count(pkt_count)
  );

  udp_byte_packer #(.PAD(8'hA5), .CNT_W(3)) dut2 (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready2),
    .m_valid(m_valid2), .m_data(m_data2), .m_keep(m_keep2), .m_last(m_last2),
    .m_ready(m_ready), .pkt_count(pkt_count2)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic wait_cycles(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    logic ok;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    forever begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 50) begin
        check("send_timeout", n, 0);
        break;
      end
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_q.push_back({d, k, l});
  endtask

  // Packet k of n bytes, byte i = 8'h10*k + i; expected words built lane by lane.
  task automatic send_pkt(input int k, input int n);
    logic [31:0] w;
    logic [3:0]  kp;
    logic [7:0]  b;
    w  = 32'hFFFF_FFFF;
    kp = 4'h0;
    for (int i = 0; i < n; i++) begin
      b = 8'(16 * k + i);
      w[31 - 8 * (i % 4) -: 8] = b;
      kp[3 - (i % 4)] = 1'b1;
      if ((i % 4 == 3) || (i == n - 1)) begin
        push_exp(w, kp, i == n - 1);
        w  = 32'hFFFF_FFFF;
        kp = 4'h0;
      end
    end
    for (int i = 0; i < n; i++) send_byte(8'(16 * k + i), i == n - 1);
  endtask

  // Scoreboard: pops one expected word per output handshake
  always @(negedge clk) begin
    logic [36:0] e;
    logic [31:0] exp2;
    if (!reset && m_valid && m_ready) begin
      check("word_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("m_data", m_data, e[36:5]);
        check("m_keep", m_keep, e[4:1]);
        check("m_last", m_last, e[0]);
        exp2 = 32'h0;
        for (int i = 0; i < 4; i++)
          exp2[31 - 8 * i -: 8] = e[4 - i] ? e[36 - 8 * i -: 8] : 8'hA5;
        check("m_valid2", m_valid2, 1);
        check("m_data2", m_data2, exp2);
        check("m_keep2", m_keep2, e[4:1]);
        check("m_last2", m_last2, e[0]);
      end
    end
  end

  task automatic settle_and_count(input string tag, input logic [15:0] c1, input logic [2:0] c2);
    idle();
    wait_cycles(3);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_pkt_count"}, pkt_count, c1);
    check({tag, "_pkt_count2"}, pkt_count2, c2);
  endtask

  initial begin
    int c0;
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    m_ready = 1'b1;
    wait_cycles(2);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 32'h0);
    check("rst_m_keep", m_keep, 4'h0);
    check("rst_m_last", m_last, 0);
    check("rst_pkt_count", pkt_count, 0);
    reset = 1'b0;
    @(negedge clk);
    check("s_ready_after_reset", s_ready, 1);
    @(posedge clk);
    #1;

    // Scenario 1: full single-word packet
    push_exp(32'hEF010203, 4'hF, 1'b1);
    send_byte(8'hEF, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 1);
    settle_and_count("s1", 16'd1, 3'd1);

    // Scenario 2: one-byte packet padded
    push_exp(32'hEFFFFFFF, 4'h8, 1'b1);
    send_byte(8'hEF, 1);
    settle_and_count("s2", 16'd2, 3'd2);

    // Scenario 3: six bytes across two words
    push_exp(32'hAABBCCDD, 4'hF, 1'b0);
    push_exp(32'h1122FFFF, 4'hC, 1'b1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 1);
    settle_and_count("s3", 16'd3, 3'd3);

    // Scenario 4: output stall with the next byte waiting
    m_ready = 1'b0;
    push_exp(32'h10203040, 4'hF, 1'b0);
    push_exp(32'h50607080, 4'hF, 1'b1);
    send_byte(8'h10, 0);
    send_byte(8'h20, 0);
    send_byte(8'h30, 0);
    send_byte(8'h40, 0);
    s_data = 8'h50;
    repeat (5) begin
      @(negedge clk);
      check("stall_s_ready", s_ready, 0);
      check("stall_s_ready2", s_ready2, 0);
      check("stall_m_valid", m_valid, 1);
      check("stall_m_data", m_data, 32'h10203040);
      check("stall_m_keep", m_keep, 4'hF);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    send_byte(8'h50, 0);
    send_byte(8'h60, 0);
    send_byte(8'h70, 0);
    send_byte(8'h80, 1);
    settle_and_count("s4", 16'd4, 3'd4);

    // Scenario 5: reset mid-packet discards partial bytes
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    idle();
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    @(negedge clk);
    check("s5_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
    wait_cycles(3);
    check("s5_no_output", m_valid, 0);
    check("s5_pkt_count_cleared", pkt_count, 0);
    push_exp(32'h01020304, 4'hF, 1'b1);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 1);
    settle_and_count("s5", 16'd1, 3'd1);

    // Scenario 6: back-to-back packets of 1..7 bytes; 3-bit counter wraps 7 -> 0
    c0 = cyc;
    for (int k = 1; k <= 7; k++) send_pkt(k, k);
    check("s6_throughput_cycles", cyc - c0, 28);
    settle_and_count("s6", 16'd8, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udp_byte_packer.md
UDP_BYTE_PACKER -- requirements
Module: udp_byte_packer

Interface
REQ-001 The block SHALL have parameter PAD, default 8'hFF, the fill byte for unused lanes of a partial final word.
REQ-002 The block SHALL have parameter CNT_W, default 16, the width of the packet counter.
REQ-003 The block SHALL have one clock, reset synchronous and active-high.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 s_valid  input  1  upstream byte valid.
REQ-007 s_data  input  8  UDP payload byte.
REQ-008 s_last  input  1  marks the final byte of a packet; qualified by s_valid.
REQ-009 s_ready  output  1  byte accepted when s_valid and s_ready are both high at a clock edge.
REQ-010 m_valid  output  1  packed word valid.
REQ-011 m_data  output  32  packed word; the first byte of a word is in [31:24].
REQ-012 m_keep  output  4  lane-valid mask; bit 3 marks [31:24].
REQ-013 m_last  output  1  the word holds the final byte of the packet.
REQ-014 m_ready  input  1  word consumed when m_valid and m_ready are both high at a clock edge.
REQ-015 pkt_count  output  CNT_W  count of packets completed on the output.

Function
REQ-016 Byte lane order SHALL be: lane 0 = [31:24], lane 1 = [23:16], lane 2 = [15:8], lane 3 = [7:0].
REQ-017 A 2-bit lane counter SHALL select the lane written by each accepted byte, starting at lane 0 after reset and after every last byte.
REQ-018 Bytes landing in lanes 0-2 without s_last SHALL be stored in an assembly register, and the lane counter SHALL increment.
REQ-019 A byte landing in lane 3, or any byte with s_last, SHALL close the word in that same cycle.
REQ-020 Closing a word SHALL load the output register with the assembled bytes plus the current byte, assert m_valid next cycle, and reset the lane counter to 0.
REQ-021 Closing a word SHALL load m_last with the s_last of the closing byte.
REQ-022 In a partial final word, lanes above the last byte SHALL carry PAD, with m_keep = 4'b1000, 4'b1100 or 4'b1110 for 1, 2 or 3 bytes.
REQ-023 A full word SHALL have m_keep = 4'b1111.
REQ-024 s_ready SHALL equal (!m_valid || m_ready), combinational, so that at most one word is held.
REQ-025 Consequence of REQ-024: s_ready is low only while an output word stalls.
REQ-026 Throughput SHALL be one byte per clock while m_ready stays high.
REQ-027 Latency SHALL be 1 cycle from the edge accepting the closing byte to m_valid high.
REQ-028 m_data, m_keep and m_last SHALL stay stable while m_valid is high and m_ready is low.
REQ-029 When an output handshake and a new word close occur on the same edge, the output register SHALL load the new word and m_valid SHALL stay high.
REQ-030 An output handshake with no word closing SHALL clear m_valid.
REQ-031 pkt_count SHALL increment by 1 on each handshake where m_last is high, and SHALL wrap from all-ones to 0.
REQ-032 s_data, s_last and the lane counter SHALL be ignored when s_valid and s_ready are not both high.
REQ-033 The assembly register contents of unwritten lanes SHALL never appear on m_data; they are replaced by PAD.

Reset
REQ-034 While reset is high at a clock edge, the block SHALL load: m_valid=0, m_data=32'h0, m_keep=4'h0, m_last=0, lane counter=0, assembly register=0, pkt_count=0.
REQ-035 s_ready SHALL be 1 in the cycle after reset is released.
REQ-036 Reset asserted mid-packet SHALL discard all partial bytes and any held output word; no word SHALL be emitted for them.
REQ-037 The first byte after reset SHALL land in lane 0.

Verification
REQ-038 Scenario 1: m_ready=1; send bytes EF,01,02,03 with s_last on 03 -> one word m_data=32'hEF010203, m_keep=4'hF, m_last=1; pkt_count=1.
REQ-039 Scenario 2: PAD=8'hFF; send single byte EF with s_last -> m_data=32'hEFFFFFFF, m_keep=4'h8, m_last=1.
REQ-040 Scenario 3: 6-byte packet AA,BB,CC,DD,11,22 -> words 32'hAABBCCDD (keep F, last 0) then 32'h1122FFFF (keep C, last 1).
REQ-041 Scenario 4: hold m_ready=0 after first word closes -> s_ready=0 and m_data held stable for 5 cycles; raise m_ready -> no byte lost or duplicated.
REQ-042 Scenario 5: assert reset after 2 bytes of a packet -> no output; the next packet 01,02,03,04 (last) yields exactly 32'h01020304.
REQ-043 Scenario 6: preset 65535 packets (CNT_W=16) -> the next completed packet wraps pkt_count to 0; back-to-back packets with m_ready=1 sustain 1 byte/clock.
